uart_tx_host_ctrl: RTL and testbench



---
 rtl/uart_tx_host_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_tx_host_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_host_ctrl.sv
// uart_tx_host_ctrl: host-side controller for a UART TX register interface.
// Runs the divisor/line/modem init sequence on start, then shares the THR
// between two byte requesters with round-robin arbitration and credit-based
// flow control against the UART TX FIFO depth.
// Optional feature macro: UART_HOST_CFG_READBACK_EN (reads LCR/MCR back after
// init and flags any mismatch on cfg_err).
module uart_tx_host_ctrl #(
  parameter logic [15:0] DIVISOR    = 16'h0146,
  parameter logic [7:0]  LCR_CFG    = 8'h0F,
  parameter logic [7:0]  MCR_CFG    = 8'h02,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_wr_en,
  output logic       uart_rd_en,
  output logic [2:0] uart_address,
  output logic [7:0] uart_data_in,
  input  logic [7:0] uart_data_o,
  input  logic       uart_tx_done,
  output logic [4:0] inflight
);

  localparam logic [4:0] DEPTH    = 5'(FIFO_DEPTH);
  localparam logic [7:0] LCR_VAL  = {1'b0, LCR_CFG[6:0]};
  localparam logic [7:0] DLAB_VAL = 8'h80;
  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL = 3'd0;
  localparam logic [2:0] ADDR_DLH = 3'd1;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_MCR = 3'd4;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    W_LCRD,
    W_DLL,
    W_DLH,
    W_LCR,
    W_MCR,
    RUN
`ifdef UART_HOST_CFG_READBACK_EN
    ,
    RB_LCR,
    RB_LCR_CHK,
    RB_MCR,
    RB_MCR_CHK
`endif
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [4:0] inflight_q, inflight_d;
  logic       cfg_done_q, cfg_done_d;
  logic       tx_done_q, tx_done_d;
  logic       uart_wr_en_q, uart_wr_en_d;
  logic [2:0] uart_address_q, uart_address_d;
  logic [7:0] uart_data_in_q, uart_data_in_d;

  logic       credit_ok;
  logic       grant_vld;
  logic       grant;
  logic       handshake;
  logic [7:0] hs_data;
  logic       done_edge;

`ifdef UART_HOST_CFG_READBACK_EN
  logic       cfg_err_q, cfg_err_d;
  logic       uart_rd_en_q, uart_rd_en_d;
`else
  logic       unused_rd_data;
  assign unused_rd_data = ^uart_data_o;
`endif

  // Round-robin grant among valid requesters, gated by RUN and FIFO credit
  always_comb begin
    credit_ok = (inflight_q < DEPTH);
    grant_vld = 1'b0;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant     = ~last_grant_q;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant     = 1'b0;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant     = 1'b1;
    end
    handshake  = (state_q == RUN) && credit_ok && grant_vld;
    req0_ready = handshake && !grant;
    req1_ready = handshake && grant;
    hs_data    = grant ? req1_data : req0_data;
  end

  // Credit counter: +1 per accepted byte, -1 per tx_done rising edge, floor 0
  always_comb begin
    tx_done_d    = uart_tx_done;
    done_edge    = uart_tx_done && !tx_done_q;
    inflight_d   = inflight_q;
    last_grant_d = handshake ? grant : last_grant_q;
    if (handshake && !done_edge) begin
      inflight_d = inflight_q + 5'd1;
    end else if (!handshake && done_edge && (inflight_q != 5'd0)) begin
      inflight_d = inflight_q - 5'd1;
    end
  end

  // Next-state logic for the init sequencer and config status flags
  always_comb begin
    state_d    = state_q;
    cfg_done_d = cfg_done_q;
`ifdef UART_HOST_CFG_READBACK_EN
    cfg_err_d  = cfg_err_q;
`endif
    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d    = DRAIN;
          cfg_done_d = 1'b0;
`ifdef UART_HOST_CFG_READBACK_EN
          cfg_err_d  = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (inflight_q == 5'd0) begin
          state_d = W_LCRD;
        end
      end
      W_LCRD: state_d = W_DLL;
      W_DLL:  state_d = W_DLH;
      W_DLH:  state_d = W_LCR;
      W_LCR:  state_d = W_MCR;
`ifdef UART_HOST_CFG_READBACK_EN
      W_MCR:  state_d = RB_LCR;
      RB_LCR: state_d = RB_LCR_CHK;
      RB_LCR_CHK: begin
        if (uart_data_o != LCR_VAL) begin
          cfg_err_d = 1'b1;
        end
        state_d = RB_MCR;
      end
      RB_MCR: state_d = RB_MCR_CHK;
      RB_MCR_CHK: begin
        if (uart_data_o != MCR_CFG) begin
          cfg_err_d = 1'b1;
        end
        state_d    = RUN;
        cfg_done_d = 1'b1;
      end
`else
      W_MCR: begin
        state_d    = RUN;
        cfg_done_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Register-interface strobes decoded from the upcoming state so each write
  // or read is presented during the cycle its state is current
  always_comb begin
    uart_wr_en_d   = 1'b0;
    uart_address_d = 3'd0;
    uart_data_in_d = 8'd0;
`ifdef UART_HOST_CFG_READBACK_EN
    uart_rd_en_d   = 1'b0;
`endif
    case (state_d)
      W_LCRD: begin
        uart_wr_en_d   = 1'b1;
        uart_address_d = ADDR_LCR;
        uart_data_in_d = DLAB_VAL;
      end
      W_DLL: begin
        uart_wr_en_d   = 1'b1;
        uart_address_d = ADDR_DLL;
        uart_data_in_d = DIVISOR[7:0];
      end
      W_DLH: begin
        uart_wr_en_d   = 1'b1;
        uart_address_d = ADDR_DLH;
        uart_data_in_d = DIVISOR[15:8];
      end
      W_LCR: begin
        uart_wr_en_d   = 1'b1;
        uart_address_d = ADDR_LCR;
        uart_data_in_d = LCR_VAL;
      end
      W_MCR: begin
        uart_wr_en_d   = 1'b1;
        uart_address_d = ADDR_MCR;
        uart_data_in_d = MCR_CFG;
      end
`ifdef UART_HOST_CFG_READBACK_EN
      RB_LCR: begin
        uart_rd_en_d   = 1'b1;
        uart_address_d = ADDR_LCR;
      end
      RB_MCR: begin
        uart_rd_en_d   = 1'b1;
        uart_address_d = ADDR_MCR;
      end
`endif
      default: ;
    endcase
    if (handshake) begin
      uart_wr_en_d   = 1'b1;
      uart_address_d = ADDR_THR;
      uart_data_in_d = hs_data;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      inflight_q     <= 5'd0;
      cfg_done_q     <= 1'b0;
      tx_done_q      <= 1'b0;
      uart_wr_en_q   <= 1'b0;
      uart_address_q <= 3'd0;
      uart_data_in_q <= 8'd0;
`ifdef UART_HOST_CFG_READBACK_EN
      cfg_err_q      <= 1'b0;
      uart_rd_en_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      inflight_q     <= inflight_d;
      cfg_done_q     <= cfg_done_d;
      tx_done_q      <= tx_done_d;
      uart_wr_en_q   <= uart_wr_en_d;
      uart_address_q <= uart_address_d;
      uart_data_in_q <= uart_data_in_d;
`ifdef UART_HOST_CFG_READBACK_EN
      cfg_err_q      <= cfg_err_d;
      uart_rd_en_q   <= uart_rd_en_d;
`endif
    end
  end

  assign cfg_busy     = (state_q != IDLE) && (state_q != RUN);
  assign cfg_done     = cfg_done_q;
  assign uart_wr_en   = uart_wr_en_q;
  assign uart_address = uart_address_q;
  assign uart_data_in = uart_data_in_q;
  assign inflight     = inflight_q;
`ifdef UART_HOST_CFG_READBACK_EN
  assign cfg_err      = cfg_err_q;
  assign uart_rd_en   = uart_rd_en_q;
`else
  assign cfg_err      = 1'b0;
  assign uart_rd_en   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_host_ctrl.sv
// tb_uart_tx_host_ctrl: randomized and directed bench for uart_tx_host_ctrl.
// A small UART register model answers readbacks; a transaction-level model
// (credit count, last winner, running flag) predicts readies and THR writes.
module tb_uart_tx_host_ctrl;

  localparam int DEPTH = 16;
  localparam logic [2:0] CFG_ADDR [5] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd4};
  localparam logic [7:0] CFG_DATA [5] = '{8'h80, 8'h46, 8'h01, 8'h0F, 8'h02};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cfg_busy, cfg_done, cfg_err;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
  logic       req0_ready, req1_ready;
  logic       uart_wr_en, uart_rd_en;
  logic [2:0] uart_address;
  logic [7:0] uart_data_in;
  logic [7:0] uart_data_o = 8'h00;
  logic       uart_tx_done = 1'b0;
  logic [4:0] inflight;

  int n_checks = 0;
  int n_fails  = 0;

  int mdl_inflight  = 0;
  int mdl_last      = 1;
  bit mdl_run       = 1'b0;
  bit mdl_prev_done = 1'b0;
  bit rb_force      = 1'b0;

  logic [7:0] uart_regs [8];

  uart_tx_host_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .uart_wr_en   (uart_wr_en),
    .uart_rd_en   (uart_rd_en),
    .uart_address (uart_address),
    .uart_data_in (uart_data_in),
    .uart_data_o  (uart_data_o),
    .uart_tx_done (uart_tx_done),
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  // Minimal UART register file: remembers writes, returns reads one cycle later
  always @(posedge clk) begin
    if (uart_wr_en) uart_regs[uart_address] <= uart_data_in;
    if (uart_rd_en) uart_data_o <= rb_force ? 8'h00 : uart_regs[uart_address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One RUN-phase cycle: drive, check readies, advance model, check THR write
  task automatic applyStimulus(input bit v0, input logic [7:0] d0,
                               input bit v1, input logic [7:0] d1, input bit done);
    bit credit, e0, e1, rise;
    int nxt;
    req0_valid   = v0;
    req0_data    = d0;
    req1_valid   = v1;
    req1_data    = d1;
    uart_tx_done = done;
    #1;
    credit = (mdl_inflight < DEPTH);
    e0 = mdl_run && credit && v0 && (!v1 || mdl_last == 1);
    e1 = mdl_run && credit && v1 && (!v0 || mdl_last == 0);
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    @(posedge clk);
    rise = done && !mdl_prev_done;
    mdl_prev_done = done;
    nxt = mdl_inflight + int'(e0 || e1) - int'(rise);
    if (nxt < 0) nxt = 0;
    mdl_inflight = nxt;
    if (e0) mdl_last = 0;
    if (e1) mdl_last = 1;
    @(negedge clk);
    checkOutput("thr_wr_en", {31'd0, uart_wr_en}, {31'd0, (e0 || e1)});
    if (e0 || e1) begin
      checkOutput("thr_addr", {29'd0, uart_address}, 32'd0);
      checkOutput("thr_data", {24'd0, uart_data_in}, {24'd0, (e0 ? d0 : d1)});
    end
    checkOutput("inflight", {27'd0, inflight}, mdl_inflight);
    checkOutput("rd_en_idle", {31'd0, uart_rd_en}, 32'd0);
  endtask

  // Return credits with tx_done pulses until the model says the FIFO is empty
  task automatic drainAll();
    for (int k = 0; k < 40 && mdl_inflight > 0; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    end
    checkOutput("drained", {27'd0, inflight}, 32'd0);
  endtask

  // Start pulse, optional drain with tx_done pulses, then the init writes
  task automatic runConfig(input int drain_pulses);
    bit exp_err;
    exp_err = 1'b0;
`ifdef UART_HOST_CFG_READBACK_EN
    exp_err = rb_force;
`endif
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    uart_tx_done = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    mdl_prev_done = 1'b0;
    mdl_run       = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_drain", {31'd0, cfg_busy}, 32'd1);
    checkOutput("done_cleared", {31'd0, cfg_done}, 32'd0);
    checkOutput("drain_no_wr", {31'd0, uart_wr_en}, 32'd0);
    for (int p = 0; p < drain_pulses; p++) begin
      uart_tx_done = 1'b1;
      req0_valid   = 1'b1;
      #1;
      checkOutput("drain_ready0", {31'd0, req0_ready}, 32'd0);
      @(posedge clk);
      mdl_inflight = (mdl_inflight > 0) ? mdl_inflight - 1 : 0;
      @(negedge clk);
      uart_tx_done = 1'b0;
      req0_valid   = 1'b0;
      checkOutput("drain_inflight", {27'd0, inflight}, mdl_inflight);
      checkOutput("drain_hold_wr", {31'd0, uart_wr_en}, 32'd0);
      if (p < drain_pulses - 1) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("drain_hold_wr2", {31'd0, uart_wr_en}, 32'd0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("cfg_wr_en", {31'd0, uart_wr_en}, 32'd1);
      checkOutput("cfg_addr", {29'd0, uart_address}, {29'd0, CFG_ADDR[i]});
      checkOutput("cfg_data", {24'd0, uart_data_in}, {24'd0, CFG_DATA[i]});
      checkOutput("cfg_busy", {31'd0, cfg_busy}, 32'd1);
      checkOutput("cfg_done_low", {31'd0, cfg_done}, 32'd0);
    end
`ifdef UART_HOST_CFG_READBACK_EN
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rb_rd_en", {31'd0, uart_rd_en}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) begin
        checkOutput("rb_addr", {29'd0, uart_address}, (i == 0) ? 32'd3 : 32'd4);
      end
      checkOutput("rb_no_wr", {31'd0, uart_wr_en}, 32'd0);
      checkOutput("rb_busy", {31'd0, cfg_busy}, 32'd1);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    checkOutput("cfg_done_set", {31'd0, cfg_done}, 32'd1);
    checkOutput("busy_run", {31'd0, cfg_busy}, 32'd0);
    checkOutput("run_no_wr", {31'd0, uart_wr_en}, 32'd0);
    checkOutput("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
    mdl_run       = 1'b1;
    mdl_prev_done = 1'b0;
  endtask

  // Abandon an init sequence by asserting reset while DLL is being written
  task automatic resetDuringDll();
    start = 1'b1;
    @(posedge clk);
    mdl_run = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_lcrd", {29'd0, uart_address}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_dll_addr", {29'd0, uart_address}, 32'd0);
    checkOutput("abort_dll_data", {24'd0, uart_data_in}, 32'h46);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_wr_en", {31'd0, uart_wr_en}, 32'd0);
    checkOutput("abort_busy", {31'd0, cfg_busy}, 32'd0);
    checkOutput("abort_done", {31'd0, cfg_done}, 32'd0);
    rst = 1'b1;
    mdl_inflight  = 0;
    mdl_last      = 1;
    mdl_prev_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    checkOutput("idle_ready0", {31'd0, req0_ready}, 32'd0);
    checkOutput("idle_busy", {31'd0, cfg_busy}, 32'd0);
    req0_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("rst_wr_en", {31'd0, uart_wr_en}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, uart_rd_en}, 32'd0);
    checkOutput("rst_addr", {29'd0, uart_address}, 32'd0);
    checkOutput("rst_data", {24'd0, uart_data_in}, 32'd0);
    checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_ready1", {31'd0, req1_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, cfg_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("rst_err", {31'd0, cfg_err}, 32'd0);
    checkOutput("rst_inflight", {27'd0, inflight}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    runConfig(0);

    // Tie between requesters: req0 wins first after reset, then alternation
    applyStimulus(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
    checkOutput("tie_first_a0", {24'd0, uart_data_in}, 32'hA0);
    repeat (5) applyStimulus(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
    drainAll();

    // Back-to-back stream from req0 only
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h57, 1'b0, 8'h00, 1'b0);
    checkOutput("stream_inflight", {27'd0, inflight}, 32'd2);
    drainAll();

    // Fill the FIFO credit, then one done edge buys exactly one more write
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    checkOutput("full_inflight", {27'd0, inflight}, 32'd16);
    applyStimulus(1'b1, 8'hC3, 1'b0, 8'h00, 1'b1);
    checkOutput("full_after_edge", {27'd0, inflight}, 32'd15);
    applyStimulus(1'b1, 8'hC4, 1'b0, 8'h00, 1'b0);
    checkOutput("refill_inflight", {27'd0, inflight}, 32'd16);
    checkOutput("refill_data", {24'd0, uart_data_in}, 32'hC4);
    applyStimulus(1'b1, 8'hC5, 1'b0, 8'h00, 1'b0);
    checkOutput("full_again_wr", {31'd0, uart_wr_en}, 32'd0);
    drainAll();

    // Simultaneous accept and completion, then completion at zero
    repeat (5) applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0, 8'h00, 1'b1);
    checkOutput("same_cycle_hold", {27'd0, inflight}, 32'd5);
    drainAll();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("sat_zero", {27'd0, inflight}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 3) == 0));
    end
    drainAll();

    // Reconfigure from RUN with three bytes still in flight
    repeat (3) applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    checkOutput("pre_restart_inflight", {27'd0, inflight}, 32'd3);
    runConfig(3);

    resetDuringDll();
    runConfig(0);
    applyStimulus(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0);
    checkOutput("tie_after_rst", {24'd0, uart_data_in}, 32'hA1);
    drainAll();

`ifdef UART_HOST_CFG_READBACK_EN
    rb_force = 1'b1;
    runConfig(0);
    rb_force = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard stop in case any wait above never completes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
